// File: rtl/md_out.sv
// md_out: sign correction, result selection and valid/ready handoff for the mul/div path
module md_out #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    kill_i,
  input  logic [3:0]              md_op_i,
  input  logic                    x_msb_i,
  input  logic                    y_msb_i,
  input  logic                    d_exception_i,
  input  logic [DATA_WIDTH-1:0]   d_exception_result_i,
  input  logic                    core_done_i,
  input  logic [2*DATA_WIDTH-1:0] prod_i,
  input  logic [DATA_WIDTH-1:0]   quot_i,
  input  logic [DATA_WIDTH-1:0]   rem_i,
  output logic [DATA_WIDTH-1:0]   result_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o
);
  typedef enum logic [1:0] {IDLE, WAIT, FIX, HOLD} state_t;
  state_t state, nxt;
  logic [3:0] op;
  logic xs, ys, neg, neg_c;
  logic [2*DATA_WIDTH-1:0] raw, fixed;
  logic [DATA_WIDTH-1:0] sel, res;
  assign busy_o = state != IDLE;
  assign valid_o = state == HOLD;
  assign neg_c = (op[0] & (op[2] | op[1])) ? 1'b0 : op[1] ? xs : xs ^ ys;
  assign fixed = neg ? -raw : raw;
  assign sel = (op[2] | op[1:0] == 2'b00) ? fixed[DATA_WIDTH-1:0] : fixed[2*DATA_WIDTH-1:DATA_WIDTH];
  assign res = op[3] ? DATA_WIDTH'($signed(sel[31:0])) : sel;
  always_comb begin
    nxt = kill_i ? IDLE :
          state == IDLE ? (start_i ? (d_exception_i ? HOLD : WAIT) : IDLE) :
          state == WAIT ? (core_done_i ? FIX : WAIT) :
          state == FIX  ? HOLD :
          (ready_i ? IDLE : HOLD);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      op <= '0;
      xs <= 1'b0;
      ys <= 1'b0;
      neg <= 1'b0;
      raw <= '0;
      result_o <= '0;
    end else if (!kill_i) begin
      if (state == IDLE && start_i) begin
        op <= md_op_i;
        xs <= x_msb_i;
        ys <= y_msb_i;
        if (d_exception_i) result_o <= d_exception_result_i;
      end
      if (state == WAIT && core_done_i) begin
        raw <= op[2] ? {{DATA_WIDTH{1'b0}}, op[1] ? rem_i : quot_i} : prod_i;
        neg <= neg_c;
      end
      if (state == FIX) result_o <= res;
    end
  end
endmodule

// File: tb/tb_md_out.sv
// tb_md_out: directed table and sequence checks of md_out at 32 and 64 bits
module tb_md_out;
  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, kill = 1'b0, core_done = 1'b0, ready = 1'b0;
  logic [3:0] md_op = '0;
  logic x_msb = 1'b0, y_msb = 1'b0, d_exc = 1'b0;
  logic [63:0] exc_res = '0, quot64 = '0, rem64 = '0;
  logic [127:0] prod64 = '0;
  logic [31:0] r32;
  logic [63:0] r64;
  logic v32, v64, b32, b64;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  md_out #(.DATA_WIDTH(32)) u32 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .kill_i(kill), .md_op_i(md_op),
    .x_msb_i(x_msb), .y_msb_i(y_msb), .d_exception_i(d_exc), .d_exception_result_i(exc_res[31:0]),
    .core_done_i(core_done), .prod_i(prod64[63:0]), .quot_i(quot64[31:0]), .rem_i(rem64[31:0]),
    .result_o(r32), .valid_o(v32), .ready_i(ready), .busy_o(b32));
  md_out #(.DATA_WIDTH(64)) u64 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .kill_i(kill), .md_op_i(md_op),
    .x_msb_i(x_msb), .y_msb_i(y_msb), .d_exception_i(d_exc), .d_exception_result_i(exc_res),
    .core_done_i(core_done), .prod_i(prod64), .quot_i(quot64), .rem_i(rem64),
    .result_o(r64), .valid_o(v64), .ready_i(ready), .busy_o(b64));
  typedef struct {
    logic [3:0] op;
    logic xs;
    logic ys;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] p;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[12];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_to_hold(input logic [3:0] op, input logic xs, input logic ys,
                             input logic [63:0] q, input logic [63:0] r, input logic [127:0] p);
    md_op = op;
    x_msb = xs;
    y_msb = ys;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_in_wait", {63'd0, b32}, 64'd1);
    tick();
    quot64 = q;
    rem64 = r;
    prod64 = p;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("valid_in_fix", {63'd0, v32}, 64'd0);
    tick();
  endtask
  task automatic release_hold();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("valid_after_ready", {63'd0, v32}, 64'd0);
    chk("busy_after_ready", {63'd0, b32}, 64'd0);
  endtask
  initial begin
    logic [31:0] held;
    tv[0]  = '{4'b0100, 1'b1, 1'b0, 32'd3, 32'd1, 64'd0, 32'hFFFFFFFD};
    tv[1]  = '{4'b0110, 1'b1, 1'b0, 32'd3, 32'd1, 64'd0, 32'hFFFFFFFF};
    tv[2]  = '{4'b0001, 1'b1, 1'b0, 32'd9, 32'd8, 64'h00000000_00000006, 32'hFFFFFFFF};
    tv[3]  = '{4'b0000, 1'b1, 1'b0, 32'd9, 32'd8, 64'h00000000_00000006, 32'hFFFFFFFA};
    tv[4]  = '{4'b0011, 1'b1, 1'b1, 32'd9, 32'd8, 64'hFFFFFFFE_00000001, 32'hFFFFFFFE};
    tv[5]  = '{4'b0010, 1'b0, 1'b1, 32'd9, 32'd8, 64'h00000001_00000000, 32'h00000001};
    tv[6]  = '{4'b0010, 1'b1, 1'b1, 32'd9, 32'd8, 64'h00000001_00000000, 32'hFFFFFFFF};
    tv[7]  = '{4'b0101, 1'b1, 1'b1, 32'd7, 32'd9, 64'd0, 32'h00000007};
    tv[8]  = '{4'b0111, 1'b1, 1'b0, 32'd7, 32'd9, 64'd0, 32'h00000009};
    tv[9]  = '{4'b0100, 1'b1, 1'b1, 32'd4, 32'd2, 64'd0, 32'h00000004};
    tv[10] = '{4'b0100, 1'b1, 1'b0, 32'd0, 32'd5, 64'd0, 32'h00000000};
    tv[11] = '{4'b0001, 1'b0, 1'b1, 32'd9, 32'd8, 64'h00000002_00000000, 32'hFFFFFFFE};
    tick();
    tick();
    chk("reset_valid", {63'd0, v32}, 64'd0);
    chk("reset_result", {32'd0, r32}, 64'd0);
    chk("reset_busy", {63'd0, b32}, 64'd0);
    chk("reset_result64", r64, 64'd0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      run_to_hold(tv[i].op, tv[i].xs, tv[i].ys, {32'd0, tv[i].q}, {32'd0, tv[i].r}, {64'd0, tv[i].p});
      chk($sformatf("vec%0d_valid", i), {63'd0, v32}, 64'd1);
      chk($sformatf("vec%0d_result", i), {32'd0, r32}, {32'd0, tv[i].exp});
      release_hold();
    end
    md_op = 4'b0100;
    d_exc = 1'b1;
    exc_res = 64'hFFFFFFFF_FFFFFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    d_exc = 1'b0;
    chk("exc_valid", {63'd0, v32}, 64'd1);
    chk("exc_result", {32'd0, r32}, 64'h00000000_FFFFFFFF);
    quot64 = 64'd3;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("exc_spurious_result", {32'd0, r32}, 64'h00000000_FFFFFFFF);
    chk("exc_spurious_valid", {63'd0, v32}, 64'd1);
    release_hold();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("idle_done_valid", {63'd0, v32}, 64'd0);
    chk("idle_done_busy", {63'd0, b32}, 64'd0);
    chk("idle_done_result", {32'd0, r32}, 64'h00000000_FFFFFFFF);
    run_to_hold(4'b0100, 1'b1, 1'b0, 64'd3, 64'd1, 128'd0);
    held = r32;
    chk("bp_first", {32'd0, held}, 64'h00000000_FFFFFFFD);
    exc_res = 64'h12345678;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      d_exc = (i == 2);
      md_op = 4'b0000;
      tick();
      start = 1'b0;
      d_exc = 1'b0;
      chk($sformatf("bp_valid%0d", i), {63'd0, v32}, 64'd1);
      chk($sformatf("bp_result%0d", i), {32'd0, r32}, {32'd0, held});
    end
    start = 1'b1;
    d_exc = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    d_exc = 1'b0;
    ready = 1'b0;
    chk("bp_release_busy", {63'd0, b32}, 64'd0);
    chk("bp_release_valid", {63'd0, v32}, 64'd0);
    tick();
    chk("bp_start_ignored", {63'd0, b32}, 64'd0);
    md_op = 4'b0100;
    x_msb = 1'b1;
    y_msb = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_wait_valid", {63'd0, v32}, 64'd0);
    chk("rst_wait_result", {32'd0, r32}, 64'd0);
    chk("rst_wait_busy", {63'd0, b32}, 64'd0);
    quot64 = 64'd3;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    chk("rst_late_done_valid", {63'd0, v32}, 64'd0);
    tick();
    chk("rst_late_done_valid2", {63'd0, v32}, 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_fix_busy", {63'd0, b32}, 64'd0);
    chk("kill_fix_valid", {63'd0, v32}, 64'd0);
    tick();
    chk("kill_fix_valid2", {63'd0, v32}, 64'd0);
    chk("kill_fix_result", {32'd0, r32}, 64'd0);
    run_to_hold(4'b1100, 1'b1, 1'b0, 64'd2, 64'd7, 128'd0);
    chk("divw64_valid", {63'd0, v64}, 64'd1);
    chk("divw64_result", r64, 64'hFFFFFFFF_FFFFFFFE);
    release_hold();
    run_to_hold(4'b1101, 1'b1, 1'b0, 64'h00000000_80000000, 64'd7, 128'd0);
    chk("divuw64_result", r64, 64'hFFFFFFFF_80000000);
    release_hold();
    run_to_hold(4'b1000, 1'b1, 1'b0, 64'd0, 64'd0, 128'd5);
    chk("mulw64_result", r64, 64'hFFFFFFFF_FFFFFFFB);
    release_hold();
    run_to_hold(4'b0011, 1'b1, 1'b1, 64'd0, 64'd0, {64'd1, 64'd0});
    chk("mulhu64_result", r64, 64'd1);
    release_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
